// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if -- request/result bundle between the MIPS core and muldiv_unit.
//
//   start  core -> unit  begin the operation selected by op (sampled in IDLE)
//   op     core -> unit  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      core -> unit  rs operand; also the MTHI/MTLO write data
//   b      core -> unit  rt operand
//   mthi   core -> unit  write a into HI (IDLE only)
//   mtlo   core -> unit  write a into LO (IDLE only)
//   busy   unit -> core  operation in flight, stalls the PC
//   done   unit -> core  one-cycle pulse after HI/LO take a new result
//   hi     unit -> core  HI register
//   lo     unit -> core  LO register
// ---------------------------------------------------------------------------
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative 32-bit multiply/divide with architectural HI/LO.
//
// Executes MULT/MULTU (shift-add, LSB first) and DIV/DIVU (restoring, MSB
// first) over 32 CALC cycles followed by one FIX cycle that applies sign
// correction and writes HI/LO. MTHI/MTLO write HI/LO directly while idle.
//
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of muldiv_if (start/op/a/b/mthi/mtlo in,
//         busy/done/hi/lo out)
// ---------------------------------------------------------------------------
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // op[1] selects divide, op[0] selects unsigned.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    op_e         op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] mag_a_q, mag_a_d;
    logic [31:0] mag_b_q, mag_b_d;
    // Multiply: {partial product high, multiplier shifting out at bit 0}.
    // Divide:   low half holds the dividend shifting out at bit 31 while
    //           quotient bits shift in at bit 0; high half stays zero.
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // ------------------------------------------------------------------
    // Operand preparation at start
    // ------------------------------------------------------------------
    logic        in_signed;
    logic        in_div;
    logic [31:0] start_mag_a;
    logic [31:0] start_mag_b;

    assign in_signed   = ~bus.op[0];
    assign in_div      = bus.op[1];
    // Two's-complement negation leaves 0x80000000 unchanged, which is the
    // correct unsigned magnitude of the most negative value.
    assign start_mag_a = (in_signed && bus.a[31]) ? -bus.a : bus.a;
    assign start_mag_b = (in_signed && bus.b[31]) ? -bus.b : bus.b;

    // ------------------------------------------------------------------
    // Per-iteration datapath
    // ------------------------------------------------------------------
    logic        op_is_div;
    logic [32:0] add_sum;
    logic [33:0] shifted;
    logic [33:0] trial;

    assign op_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Multiply step: add multiplicand when the current multiplier bit is
    // set, then shift the whole accumulator right by one (carry included).
    assign add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);

    // Divide step: bring the next dividend bit into the partial remainder
    // and try subtracting the divisor; a borrow (trial[33]) means restore.
    assign shifted = {rem_q, acc_q[31]};
    assign trial   = shifted - {2'b00, mag_b_q};

    // ------------------------------------------------------------------
    // Sign correction for the FIX cycle
    // ------------------------------------------------------------------
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic [63:0] prod;
    logic        neg_result;

    // Sign flags are only ever set for the signed ops, so no op check here.
    assign neg_result = sign_a_q ^ sign_b_q;
    assign prod       = neg_result ? -acc_q : acc_q;

    always_comb begin
        fix_hi = prod[63:32];
        fix_lo = prod[31:0];
        if (op_is_div) begin
            if (mag_b_q == 32'd0) begin
                // Divide by zero: quotient all ones, remainder is the
                // dividend exactly as it was presented.
                fix_lo = 32'hFFFF_FFFF;
                fix_hi = sign_a_q ? -mag_a_q : mag_a_q;
            end else begin
                fix_lo = neg_result ? -acc_q[31:0] : acc_q[31:0];
                fix_hi = sign_a_q ? -rem_q[31:0] : rem_q[31:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every _d signal is given its hold value before the case, so
    // no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // start wins over a simultaneous MTHI/MTLO.
                    op_d     = op_e'(bus.op);
                    sign_a_d = in_signed & bus.a[31];
                    sign_b_d = in_signed & bus.b[31];
                    mag_a_d  = start_mag_a;
                    mag_b_d  = start_mag_b;
                    acc_d    = in_div ? {32'd0, start_mag_a} : {32'd0, start_mag_b};
                    rem_d    = 33'd0;
                    cnt_d    = 5'd31;
                    state_d  = S_CALC;
                end else begin
                    if (bus.mthi) hi_d = bus.a;
                    if (bus.mtlo) lo_d = bus.a;
                end
            end

            S_CALC: begin
                if (op_is_div) begin
                    rem_d = trial[33] ? shifted[32:0] : trial[32:0];
                    acc_d = {acc_q[63:32], acc_q[30:0], ~trial[33]};
                end else begin
                    acc_d = {add_sum, acc_q[31:1]};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = S_FIX;
            end

            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    // NOTE: working registers are cleared on reset too, not just the
    // architectural ones, so an aborted operation leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            acc_q    <= 64'd0;
            rem_q    <= 33'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from registers
    // ------------------------------------------------------------------
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit -- scoreboard bench for muldiv_unit.
//
// Stimulus pushes the expected {hi,lo} of every started operation into a
// queue; an independent monitor pops and compares on each done pulse.
// Expected results come from plain 64-bit arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                p = 64'(sa * sb);
                return p;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every result the unit presents.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                check("done_single_pulse", 64'(prev_done), 64'd0);
                if (exp_q.size() == 0)
                    check("done_unexpected", 64'(exp_q.size()), 64'd1);
                else
                    check("hi_lo_result", {bus.hi, bus.lo}, exp_q.pop_front());
            end
            prev_done = bus.done;
        end
    end

    // Called just after a negedge with busy low. Returns just after the
    // negedge at which busy has fallen (done visible to the monitor).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit with_mt);
        logic [63:0] r;
        logic [31:0] old_hi, old_lo;
        int          busy_cyc;
        r        = ref_model(op, a, b);
        old_hi   = m_hi;
        old_lo   = m_lo;
        busy_cyc = 0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.mthi  = with_mt;
        bus.mtlo  = 1'b0;
        exp_q.push_back(r);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        // Operands changing after the start edge must have no effect.
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom;
        bus.b     = $urandom;
        while (bus.busy && busy_cyc < 100) begin
            busy_cyc++;
            check("hi_lo_hold_busy", {bus.hi, bus.lo}, {old_hi, old_lo});
            if (disturb && busy_cyc == 5) begin
                bus.start = 1'b1;
                bus.mthi  = 1'b1;
                bus.mtlo  = 1'b1;
                bus.a     = 32'hDEAD_BEEF;
            end else if (disturb && busy_cyc == 6) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
                bus.mtlo  = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_cycles", 64'(busy_cyc), 64'd33);
        m_hi = r[63:32];
        m_lo = r[31:0];
        if (disturb) begin
            @(negedge clk);
            check("no_second_op", 64'(bus.busy), 64'd0);
            check("hi_lo_after_disturb", {bus.hi, bus.lo}, r);
        end
    endtask

    task automatic mt_write(input bit hi_en, input bit lo_en, input logic [31:0] val);
        bus.mthi = hi_en;
        bus.mtlo = lo_en;
        bus.a    = val;
        @(posedge clk);
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (hi_en) m_hi = val;
        if (lo_en) m_lo = val;
        check("mt_hi", 64'(bus.hi), 64'(m_hi));
        check("mt_lo", 64'(bus.lo), 64'(m_lo));
        check("mt_no_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);

        // MTHI/MTLO in IDLE
        mt_write(1'b1, 1'b1, 32'hA5A5_A5A5);
        mt_write(1'b1, 1'b0, 32'h1357_9BDF);
        mt_write(1'b0, 1'b1, 32'h2468_ACE0);

        // Reset in the middle of CALC discards the operation.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd5;
        bus.b     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midcalc_reset_hi", 64'(bus.hi), 64'd0);
        check("midcalc_reset_lo", 64'(bus.lo), 64'd0);
        check("midcalc_reset_busy", 64'(bus.busy), 64'd0);
        check("midcalc_reset_done", 64'(bus.done), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed operations (issued back-to-back)
        run_op(2'b01, 32'd5, 32'd7, 1'b0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        run_op(2'b11, 32'd7, 32'd2, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b10, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_EDCC, 32'd0, 1'b0, 1'b0);
        run_op(2'b00, 32'd12345, 32'hFFFF_FFF9, 1'b1, 1'b0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) mt_write(1'($urandom_range(0, 1)), 1'b1, $urandom);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
